// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the MEM-stage load/store unit.
//   mem_mask_e   : normalised access size/sign code (from funct3)
//   mem_state_e  : bus-transaction FSM states
//   mem_req_t    : request captured at issue and held for the whole transaction
//   decode_mask  : funct3 -> mem_mask_e (unused codes fall back to word)
//   is_misaligned: alignment rule for a given size and byte offset
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [2:0] {
        MASK_B  = 3'b000,
        MASK_H  = 3'b001,
        MASK_W  = 3'b010,
        MASK_BU = 3'b100,
        MASK_HU = 3'b101
    } mem_mask_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        mem_mask_e   mask;
        logic [1:0]  off;
    } mem_req_t;

    // Codes 011/110/111 have no defined meaning and are handled as full words.
    function automatic mem_mask_e decode_mask(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return MASK_B;
            3'b001:  return MASK_H;
            3'b100:  return MASK_BU;
            3'b101:  return MASK_HU;
            default: return MASK_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_mask_e mask, input logic [1:0] off);
        case (mask)
            MASK_H, MASK_HU: return off[0];
            MASK_W:          return off != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load alignment: selects the addressed byte/halfword lane of the
// bus read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata     in  32  word returned by the bus
//   off       in  2   byte offset of the access within the word
//   mask      in      access size/sign (mem_mask_e)
//   load_data out 32  extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  mem_mask_e   mask,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal written here gets a value before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        byte_sel = 8'(rdata >> {off, 3'b000});
        // Halfwords are aligned, so only off[1] picks the lane.
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (mask)
            MASK_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MASK_BU: load_data = {24'h0, byte_sel};
            MASK_H:  load_data = {{16{half_sel[15]}}, half_sel};
            MASK_HU: load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage responder: turns one load/store from the EX/MEM register into a
// single word-aligned bus transaction (valid/ready request, pulsed response),
// stalls the pipeline until it completes and returns the aligned load result.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   mem_rd_M, mem_wr_M            load / store request (both set = load)
//   mem_mask_M[2:0]               funct3 size/sign code
//   alu_o_M[31:0]                 byte address
//   wr_data_M[31:0]               store data, LSB-justified
//   stall_M                       hold IF..MEM pipeline registers
//   rd_data_M[31:0]               load result, valid in DONE
//   misalign_M                    misaligned access (IDLE only, combinational)
//   bus_err_M                     one-cycle pulse when a response times out
//   bus_req_valid/bus_req_ready   request handshake
//   bus_we, bus_addr, bus_be,
//   bus_wdata                     request fields
//   bus_rsp_valid, bus_rdata      response pulse and read word
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic [2:0]  mem_mask_M,
    input  logic [31:0] alu_o_M,
    input  logic [31:0] wr_data_M,
    output logic        stall_M,
    output logic [31:0] rd_data_M,
    output logic        misalign_M,
    output logic        bus_err_M,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_e       state_q, state_d;
    mem_req_t         req_q, req_d, req_now;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             bus_err_q, bus_err_d;
    logic [31:0]      load_data;
    mem_mask_e        mask_now;
    logic             access, misaligned, active;

    // Decode of the pipeline inputs into a bus request (used only in IDLE).
    always_comb begin
        mask_now      = decode_mask(mem_mask_M);
        access        = mem_rd_M | mem_wr_M;
        misaligned    = is_misaligned(mask_now, alu_o_M[1:0]);
        active        = access & ~misaligned;
        req_now       = '0;
        req_now.we    = mem_wr_M & ~mem_rd_M;
        req_now.addr  = {alu_o_M[31:2], 2'b00};
        req_now.mask  = mask_now;
        req_now.off   = alu_o_M[1:0];
        case (mask_now)
            MASK_B, MASK_BU: begin
                req_now.be    = 4'b0001 << alu_o_M[1:0];
                req_now.wdata = {4{wr_data_M[7:0]}};
            end
            MASK_H, MASK_HU: begin
                req_now.be    = 4'b0011 << alu_o_M[1:0];
                req_now.wdata = {2{wr_data_M[15:0]}};
            end
            default: begin
                req_now.be    = 4'hF;
                req_now.wdata = wr_data_M;
            end
        endcase
        if (!req_now.we) begin
            req_now.be = 4'hF;
        end
    end

    lsu_load_align u_load_align (
        .rdata     (bus_rdata),
        .off       (req_q.off),
        .mask      (req_q.mask),
        .load_data (load_data)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        wait_cnt_d    = wait_cnt_q;
        rd_data_d     = rd_data_q;
        bus_err_d     = 1'b0;
        bus_req_valid = 1'b0;
        stall_M       = 1'b0;
        misalign_M    = 1'b0;
        bus_we        = req_q.we;
        bus_addr      = req_q.addr;
        bus_be        = req_q.be;
        bus_wdata     = req_q.wdata;

        case (state_q)
            IDLE: begin
                misalign_M = access & misaligned;
                if (active) begin
                    // Issue in the same cycle: bus fields come straight from
                    // the inputs while they are being latched.
                    req_d         = req_now;
                    bus_we        = req_now.we;
                    bus_addr      = req_now.addr;
                    bus_be        = req_now.be;
                    bus_wdata     = req_now.wdata;
                    bus_req_valid = 1'b1;
                    stall_M       = 1'b1;
                    state_d       = bus_req_ready ? WAIT : REQ;
                end
            end
            REQ: begin
                bus_req_valid = 1'b1;
                stall_M       = 1'b1;
                if (bus_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_M    = 1'b1;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (bus_rsp_valid) begin
                    rd_data_d  = req_q.we ? 32'h0 : load_data;
                    wait_cnt_d = '0;
                    state_d    = DONE;
                end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    // This is the MAX_WAIT-th silent cycle: abandon the access.
                    rd_data_d  = 32'h0;
                    bus_err_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of block ordering.
    // NOTE: all of these are control/result registers (no memory arrays), so
    // each one is cleared by reset to make every output start at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            wait_cnt_q <= '0;
            rd_data_q  <= 32'h0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wait_cnt_q <= wait_cnt_d;
            rd_data_q  <= rd_data_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign rd_data_M = rd_data_q;
    assign bus_err_M = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed table of single transactions plus hand-written sequences for
// request back-pressure, response timeout and reset during WAIT.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int unsigned MAX_WAIT = 64;

    logic        clk;
    logic        rst;
    logic        mem_rd_M, mem_wr_M;
    logic [2:0]  mem_mask_M;
    logic [31:0] alu_o_M, wr_data_M;
    logic        stall_M;
    logic [31:0] rd_data_M;
    logic        misalign_M, bus_err_M;
    logic        bus_req_valid, bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rd = 32'h0;

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_M      (mem_rd_M),
        .mem_wr_M      (mem_wr_M),
        .mem_mask_M    (mem_mask_M),
        .alu_o_M       (alu_o_M),
        .wr_data_M     (wr_data_M),
        .stall_M       (stall_M),
        .rd_data_M     (rd_data_M),
        .misalign_M    (misalign_M),
        .bus_err_M     (bus_err_M),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_mis;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input string n, input logic rd, input logic wr,
                                input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdt,
                                input logic mis, input logic we, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] erd);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.mask = m; v.addr = a; v.wdata = wd;
        v.rdata = rdt; v.exp_mis = mis; v.exp_we = we; v.exp_be = be;
        v.exp_wdata = ewd; v.exp_rd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_rd_M      = 1'b0;
        mem_wr_M      = 1'b0;
        mem_mask_M    = 3'b000;
        alu_o_M       = 32'h0;
        wr_data_M     = 32'h0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'h0;
    endtask

    // One transaction with ready=1 at issue and the response in the next cycle.
    // Entered and left just after a rising edge.
    task automatic run_vec(input vec_t v);
        mem_rd_M      = v.rd;
        mem_wr_M      = v.wr;
        mem_mask_M    = v.mask;
        alu_o_M       = v.addr;
        wr_data_M     = v.wdata;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        check({v.name, " misalign"}, 32'(misalign_M), 32'(v.exp_mis));
        if (v.exp_mis) begin
            check({v.name, " req_valid"}, 32'(bus_req_valid), 32'h0);
            check({v.name, " stall"}, 32'(stall_M), 32'h0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check({v.name, " rd_data kept"}, rd_data_M, last_rd);
            check({v.name, " stall after"}, 32'(stall_M), 32'h0);
            @(posedge clk); #1;
        end else begin
            check({v.name, " req_valid"}, 32'(bus_req_valid), 32'h1);
            check({v.name, " stall issue"}, 32'(stall_M), 32'h1);
            check({v.name, " addr"}, bus_addr, {v.addr[31:2], 2'b00});
            check({v.name, " be"}, 32'(bus_be), 32'(v.exp_be));
            check({v.name, " we"}, 32'(bus_we), 32'(v.exp_we));
            if (v.exp_we) check({v.name, " wdata"}, bus_wdata, v.exp_wdata);
            @(posedge clk); #1;
            idle_inputs();
            bus_rsp_valid = 1'b1;
            bus_rdata     = v.rdata;
            @(negedge clk);
            check({v.name, " stall wait"}, 32'(stall_M), 32'h1);
            check({v.name, " req_valid wait"}, 32'(bus_req_valid), 32'h0);
            @(posedge clk); #1;
            bus_rsp_valid = 1'b0;
            bus_rdata     = 32'h0;
            @(negedge clk);
            check({v.name, " stall done"}, 32'(stall_M), 32'h0);
            check({v.name, " rd_data"}, rd_data_M, v.exp_rd);
            check({v.name, " bus_err"}, 32'(bus_err_M), 32'h0);
            last_rd = v.exp_rd;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  n_wait;
        bit  seen_err;
        bit  stall_ok;

        vecs[0]  = mk("LW_100",   1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'hF, 32'h0,        32'hDEADBEEF);
        vecs[1]  = mk("LB_103",   1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 0, 4'hF, 32'h0,        32'hFFFFFF80);
        vecs[2]  = mk("LBU_103",  1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 0, 4'hF, 32'h0,        32'h00000080);
        vecs[3]  = mk("LHU_102",  1, 0, 3'b101, 32'h102, 32'h0,        32'h80112233, 0, 0, 4'hF, 32'h0,        32'h00008011);
        vecs[4]  = mk("LH_102",   1, 0, 3'b001, 32'h102, 32'h0,        32'h80112233, 0, 0, 4'hF, 32'h0,        32'hFFFF8011);
        vecs[5]  = mk("LB_101",   1, 0, 3'b000, 32'h101, 32'h0,        32'h80112233, 0, 0, 4'hF, 32'h0,        32'h00000022);
        vecs[6]  = mk("LW_101",   1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0);
        vecs[7]  = mk("SH_102",   0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h55555555, 0, 1, 4'hC, 32'hABCDABCD, 32'h0);
        vecs[8]  = mk("SB_101",   0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h55555555, 0, 1, 4'h2, 32'hA5A5A5A5, 32'h0);
        vecs[9]  = mk("SW_104",   0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h55555555, 0, 1, 4'hF, 32'hCAFEF00D, 32'h0);
        vecs[10] = mk("LHU_100",  1, 0, 3'b101, 32'h100, 32'h0,        32'h80112233, 0, 0, 4'hF, 32'h0,        32'h00002233);
        vecs[11] = mk("SH_103",   0, 1, 3'b001, 32'h103, 32'h1234ABCD, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0);
        vecs[12] = mk("LH_101",   1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0);
        vecs[13] = mk("RDWR_108", 1, 1, 3'b010, 32'h108, 32'h11112222, 32'h0BADF00D, 0, 0, 4'hF, 32'h0,        32'h0BADF00D);
        vecs[14] = mk("M011_10C", 1, 0, 3'b011, 32'h10C, 32'h0,        32'h01234567, 0, 0, 4'hF, 32'h0,        32'h01234567);
        vecs[15] = mk("M111_10D", 1, 0, 3'b111, 32'h10D, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0);
        vecs[16] = mk("M110_110", 1, 0, 3'b110, 32'h110, 32'h0,        32'h89ABCDEF, 0, 0, 4'hF, 32'h0,        32'h89ABCDEF);

        // Reset state.
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst stall", 32'(stall_M), 32'h0);
        check("rst req_valid", 32'(bus_req_valid), 32'h0);
        check("rst misalign", 32'(misalign_M), 32'h0);
        check("rst bus_err", 32'(bus_err_M), 32'h0);
        check("rst rd_data", rd_data_M, 32'h0);
        check("rst addr", bus_addr, 32'h0);
        check("rst be_we", {27'h0, bus_we, bus_be}, 32'h0);
        check("rst wdata", bus_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: ready low for 3 cycles while the pipeline inputs change.
        mem_rd_M   = 1'b1;
        mem_mask_M = 3'b010;
        alu_o_M    = 32'h200;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus_req_ready = 1'b1;
            @(negedge clk);
            check($sformatf("bp%0d req_valid", c), 32'(bus_req_valid), 32'h1);
            check($sformatf("bp%0d stall", c), 32'(stall_M), 32'h1);
            check($sformatf("bp%0d addr", c), bus_addr, 32'h200);
            check($sformatf("bp%0d be_we", c), {27'h0, bus_we, bus_be}, 32'h0000000F);
            @(posedge clk); #1;
            if (c == 0) begin
                mem_rd_M   = 1'b0;
                mem_wr_M   = 1'b1;
                mem_mask_M = 3'b000;
                alu_o_M    = 32'h301;
                wr_data_M  = 32'h77;
            end
        end
        idle_inputs();

        // No response: count WAIT cycles until the timeout pulse.
        n_wait   = 0;
        seen_err = 1'b0;
        stall_ok = 1'b1;
        for (int c = 0; c < 3 * MAX_WAIT && !seen_err; c++) begin
            @(negedge clk);
            if (bus_err_M) begin
                seen_err = 1'b1;
            end else begin
                if (!stall_M || bus_req_valid) stall_ok = 1'b0;
                n_wait++;
                @(posedge clk); #1;
            end
        end
        check("timeout seen", 32'(seen_err), 32'h1);
        check("timeout wait cycles", 32'(n_wait), 32'(MAX_WAIT));
        check("timeout stall during wait", 32'(stall_ok), 32'h1);
        check("timeout stall done", 32'(stall_M), 32'h0);
        check("timeout rd_data", rd_data_M, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("timeout err pulse width", 32'(bus_err_M), 32'h0);
        check("timeout back idle", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        last_rd = 32'h0;

        // Put a non-zero value in rd_data_M so the reset clear is visible.
        run_vec(mk("LW_104", 1, 0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 0, 0, 4'hF, 32'h0, 32'h13579BDF));

        // Reset while waiting for a response.
        mem_rd_M      = 1'b1;
        mem_mask_M    = 3'b010;
        alu_o_M       = 32'h400;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("rstwait stall before", 32'(stall_M), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rstwait stall", 32'(stall_M), 32'h0);
        check("rstwait req_valid", 32'(bus_req_valid), 32'h0);
        check("rstwait rd_data", rd_data_M, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hFFFFFFFF;
        @(negedge clk);
        check("stale rsp stall", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("stale rsp rd_data", rd_data_M, 32'h0);
        check("stale rsp stall after", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        last_rd = 32'h0;

        run_vec(mk("LW_108", 1, 0, 3'b010, 32'h108, 32'h0, 32'h2468ACE0, 0, 0, 4'hF, 32'h0, 32'h2468ACE0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
